// File: rtl/spi_tx_engine.sv
// rtl/spi_tx_engine.sv - SPI master word engine fed from a first-word-fall-through FIFO
module spi_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  done
);

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int DIV_CNT_W = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, LOAD, LEAD, SHIFT, TRAIL} state_t;

  state_t                state_q, state_d;
  logic [DIV_CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  phase_q, phase_d;   // 0: next sclk edge is leading, 1: trailing
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;

  logic                  div_tick;
  logic                  tx_out_bit;
  logic [DATA_WIDTH-1:0] tx_shifted;
  logic [DATA_WIDTH-1:0] rx_shifted;

  assign div_tick   = (div_cnt_q == DIV_CNT_W'(CLK_DIV - 1));
  assign tx_out_bit = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_WIDTH-1];
  assign tx_shifted = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
  assign rx_shifted = lsb_q ? {miso, rx_sh_q[DATA_WIDTH-1:1]} : {rx_sh_q[DATA_WIDTH-2:0], miso};

  assign rd_en    = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign done     = done_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

  // Next-state and datapath: sequencing of one word through LOAD/LEAD/SHIFT/TRAIL
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;

    case (state_q)
      IDLE: begin
        sclk_d    = cpol;
        cs_n_d    = 1'b1;
        div_cnt_d = '0;
        if (!empty) state_d = LOAD;
      end

      LOAD: begin
        // sclk_q itself carries the frozen idle level for the rest of the word
        sclk_d    = cpol;
        cpha_d    = cpha;
        lsb_d     = lsb_first;
        bit_cnt_d = BIT_CNT_W'(DATA_WIDTH);
        phase_d   = 1'b0;
        div_cnt_d = '0;
        rx_sh_d   = '0;
        cs_n_d    = 1'b0;
        if (!cpha) begin
          // leading-edge sampling needs the first bit on the wire before sclk moves
          mosi_d  = lsb_first ? rd_data[0] : rd_data[DATA_WIDTH-1];
          tx_sh_d = lsb_first ? (rd_data >> 1) : (rd_data << 1);
        end else begin
          tx_sh_d = rd_data;
        end
        state_d = LEAD;
      end

      LEAD: begin
        if (div_tick) begin
          div_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end

      SHIFT: begin
        if (div_tick) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          phase_d   = ~phase_q;
          if (!phase_q) begin
            if (cpha_q) begin
              mosi_d  = tx_out_bit;
              tx_sh_d = tx_shifted;
            end else begin
              rx_sh_d = rx_shifted;
            end
          end else begin
            if (cpha_q) begin
              rx_sh_d = rx_shifted;
            end else if (bit_cnt_q != BIT_CNT_W'(1)) begin
              mosi_d  = tx_out_bit;
              tx_sh_d = tx_shifted;
            end
            bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
            if (bit_cnt_q == BIT_CNT_W'(1)) state_d = TRAIL;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end

      TRAIL: begin
        if (div_tick) begin
          div_cnt_d  = '0;
          done_d     = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh_q;
          if (!empty) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
    end
  end

endmodule

// File: tb/tb_spi_tx_engine.sv
// tb/tb_spi_tx_engine.sv - scoreboard bench for spi_tx_engine with miso looped back to mosi
module tb_spi_tx_engine;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpol = 1'b0;
  logic          cpha = 1'b0;
  logic          lsb_first = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic          miso;
  logic          rd_en, sclk, mosi, cs_n, busy, rx_valid, done;
  logic [DW-1:0] rx_data;

  assign miso = mosi;

  always #5 clk = ~clk;

  spi_tx_engine #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .empty(empty), .rd_data(rd_data), .rd_en(rd_en), .miso(miso),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done)
  );

  typedef struct {
    logic [7:0] rx;
    logic [7:0] seq;
    logic       cpol;
    logic       cpha;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] fifo[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_low = 36;
  int         rd_cnt = 0;
  int         done_cnt = 0;
  logic       rd_seen = 1'b0;
  int         tb_edges = 0;
  logic       tb_prev_sclk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: collects mosi at slave sampling edges and checks each finished word
  int         m_edges = 0;
  int         m_low = 0;
  logic [7:0] m_seq = '0;
  logic       m_prev_sclk = 1'b0;
  logic       m_prev_csn = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      m_edges = 0;
      m_low = 0;
      m_seq = '0;
      m_prev_sclk = sclk;
      m_prev_csn = cs_n;
    end else begin
      if (!cs_n) begin
        m_low++;
        if (sclk != m_prev_sclk) begin
          m_edges++;
          if (sb.size() > 0 && ((m_edges % 2 == 1) != sb[0].cpha))
            m_seq = {m_seq[6:0], mosi};
        end
      end else if (!m_prev_csn) begin
        check("cs_n_low_cycles", 32'(m_low), 32'(exp_low));
        m_low = 0;
      end
      if (done) begin
        exp_t e;
        done_cnt++;
        check("word_pending_at_done", 32'(sb.size() != 0), 1);
        check("rx_valid_with_done", 32'(rx_valid), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.rx));
          check("mosi_sequence", 32'(m_seq), 32'(e.seq));
          check("sclk_edges_per_word", 32'(m_edges), 16);
          check("sclk_idle_at_word_end", 32'(sclk), 32'(e.cpol));
        end
        m_edges = 0;
        m_seq = '0;
      end
      m_prev_sclk = sclk;
      m_prev_csn = cs_n;
    end
  end

  task automatic update_fifo();
    empty = (fifo.size() == 0);
    rd_data = empty ? '0 : fifo[0];
  endtask

  // One clock step; the FIFO pop is applied a cycle after rd_en so rd_data is stable through LOAD
  task automatic tick();
    logic [7:0] dummy;
    @(negedge clk);
    if (rd_seen && fifo.size() != 0) dummy = fifo.pop_front();
    rd_seen = rd_en;
    if (rd_en) begin
      rd_cnt++;
      check("rd_en_while_empty", 32'(empty), 0);
    end
    if (!cs_n) begin
      if (sclk != tb_prev_sclk) tb_edges++;
    end else begin
      tb_edges = 0;
    end
    tb_prev_sclk = sclk;
    update_fifo();
  endtask

  task automatic push_word(input logic [7:0] d, input logic [7:0] seq);
    exp_t e;
    e.rx = d;
    e.seq = seq;
    e.cpol = cpol;
    e.cpha = cpha;
    fifo.push_back(d);
    sb.push_back(e);
    update_fifo();
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n = 0;
    while (!(!busy && fifo.size() == 0 && sb.size() == 0) && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, 32'(n < max_cycles), 1);
    repeat (3) tick();
  endtask

  task automatic wait_edges(input string name, input int count);
    int n = 0;
    while (tb_edges < count && n < 200) begin
      tick();
      n++;
    end
    check(name, 32'(n < 200), 1);
  endtask

  task automatic single_word(input string name, input logic p, input logic h, input logic l,
                             input logic [7:0] d, input logic [7:0] seq);
    int rd0, dn0;
    cpol = p;
    cpha = h;
    lsb_first = l;
    exp_low = 36;
    tick();
    rd0 = rd_cnt;
    dn0 = done_cnt;
    push_word(d, seq);
    wait_idle(name, 200);
    check({name, "_rd_en_count"}, 32'(rd_cnt - rd0), 1);
    check({name, "_done_count"}, 32'(done_cnt - dn0), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sclk"}, 32'(sclk), 0);
    check({tag, "_mosi"}, 32'(mosi), 0);
    check({tag, "_cs_n"}, 32'(cs_n), 1);
    check({tag, "_rd_en"}, 32'(rd_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 0);
    check({tag, "_rx_data"}, 32'(rx_data), 0);
  endtask

  initial begin
    int rd0, dn0;
    exp_t gone;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();

    // Single words across the four modes and both bit orders
    single_word("mode0_msb_a5", 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5);
    single_word("mode3_lsb_3c", 1'b1, 1'b1, 1'b1, 8'h3C, 8'h3C);
    single_word("mode1_msb_5a", 1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A);
    single_word("mode2_lsb_96", 1'b1, 1'b0, 1'b1, 8'h96, 8'h69);
    single_word("mode0_lsb_01", 1'b0, 1'b0, 1'b1, 8'h01, 8'h80);

    // Burst of three pre-loaded words keeps cs_n low throughout
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    exp_low = 110;
    tick();
    rd0 = rd_cnt; dn0 = done_cnt;
    push_word(8'h01, 8'h01);
    push_word(8'h02, 8'h02);
    push_word(8'h03, 8'h03);
    wait_idle("burst_drain", 400);
    check("burst_rd_en_count", 32'(rd_cnt - rd0), 3);
    check("burst_done_count", 32'(done_cnt - dn0), 3);

    // FIFO drained mid-SHIFT: current word completes, no further pop
    exp_low = 36;
    tick();
    rd0 = rd_cnt; dn0 = done_cnt;
    push_word(8'hF0, 8'hF0);
    push_word(8'h0F, 8'h0F);
    wait_edges("empty_mid_shift_reach", 6);
    fifo.delete();
    gone = sb.pop_back();
    update_fifo();
    wait_idle("empty_mid_shift_drain", 200);
    check("empty_mid_shift_rd_en_count", 32'(rd_cnt - rd0), 1);
    check("empty_mid_shift_done_count", 32'(done_cnt - dn0), 1);

    // Reset at the 5th sclk edge abandons the word
    tick();
    dn0 = done_cnt;
    push_word(8'h7F, 8'h7F);
    wait_edges("mid_word_reset_reach", 5);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_word_reset");
    gone = sb.pop_front();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("after_reset_idle_busy", 32'(busy), 0);
    check("after_reset_idle_cs_n", 32'(cs_n), 1);
    check("mid_word_reset_no_done", 32'(done_cnt - dn0), 0);
    single_word("after_reset_7e", 1'b0, 1'b0, 1'b0, 8'h7E, 8'h7E);

    // cpol changed mid-SHIFT only takes effect at the next LOAD
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    exp_low = 36;
    tick();
    push_word(8'hA5, 8'hA5);
    wait_edges("cpol_change_reach", 7);
    cpol = 1'b1;
    wait_idle("cpol_change_drain", 200);
    single_word("cpol_new_42", 1'b1, 1'b0, 1'b0, 8'h42, 8'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
